// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: slot-state encoding plus per-boundary
// payload widths and bubble (no-side-effect) control encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;

  // IF/ID: PC, PC+4, instruction
  localparam int unsigned IFID_DATA_W  = 3 * XLEN;
  localparam int unsigned IFID_CTRL_W  = 1;
  localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_RST = '0;

  // ID/EX: PC+4, imm, rs1/rs2 values, rd
  localparam int unsigned IDEX_DATA_W  = 4 * XLEN + REG_AW;
  localparam int unsigned IDEX_CTRL_W  = 12;
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_RST = '0;

  // EX/MEM: PC+4, ALU result, store data, rd
  localparam int unsigned EXMEM_DATA_W = 3 * XLEN + REG_AW;
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_RST = '0;

  // MEM/WB: PC+4, ALU result, load data, rd
  localparam int unsigned MEMWB_DATA_W = 3 * XLEN + REG_AW;
  localparam int unsigned MEMWB_CTRL_W = 3;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_RST = '0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// registered in_ready and flush-to-bubble.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = 128,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_push;
  logic w_pop;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid_in;
  logic w_clr_main;
  logic w_clr_skid;

  assign out_valid = (r_state != PIPE_EMPTY);
  assign in_ready  = r_in_ready;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_clr_main     = 1'b0;
    w_clr_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = PIPE_EMPTY;
      w_clr_main  = 1'b1;
      w_clr_skid  = 1'b1;
    end else begin
      case (r_state)
        PIPE_EMPTY: begin
          if (w_push) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = PIPE_ONE;
          end
        end
        PIPE_ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            w_ld_skid_in = 1'b1;
            w_state_nxt  = PIPE_TWO;
          end else if (w_pop) begin
            w_clr_main   = 1'b1;
            w_state_nxt  = PIPE_EMPTY;
          end
        end
        PIPE_TWO: begin
          // in_ready is low here, so only the skid-to-main move can happen
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_clr_skid     = 1'b1;
            w_state_nxt    = PIPE_ONE;
          end
        end
        default: w_state_nxt = PIPE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PIPE_EMPTY;
      r_in_ready  <= 1'b0;
      r_main_ctrl <= CTRL_RST;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_RST;
      r_skid_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != PIPE_TWO);

      if (w_clr_main)          r_main_ctrl <= CTRL_RST;
      else if (w_ld_main_in)   r_main_ctrl <= in_ctrl;
      else if (w_ld_main_skid) r_main_ctrl <= r_skid_ctrl;

      // data banks only move on a load; clears touch control alone
      if (w_ld_main_in)        r_main_data <= in_data;
      else if (w_ld_main_skid) r_main_data <= r_skid_data;

      if (w_clr_skid)          r_skid_ctrl <= CTRL_RST;
      else if (w_ld_skid_in)   r_skid_ctrl <= in_ctrl;

      if (w_ld_skid_in)        r_skid_data <= in_data;
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Generic, parametrised pipeline-stage register; successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the bare stall/hold input with a valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered and back-pressure never forms a combinational path across the stage.
- Adds flush with bubble insertion: control fields forced to a safe value, data held.
- Instantiated between every pair of CPU pipeline stages.

Parameters:
- DATA_W, 128, width of datapath payload (imm, PC+4, ALU result, store data, rd, etc. concatenated by the instantiating stage).
- CTRL_W, 8, width of control payload (mem_r, mem_w, reg_w, wb_sel, strb, ...).
- CTRL_RST, {CTRL_W{1'b0}}, control value for reset/bubble/flush; must encode a no-side-effect instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries this cycle (branch mispredict/trap).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered output.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream data payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main-entry control; CTRL_RST whenever out_valid=0.
- out_data  out  DATA_W  main-entry data.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main register (drives out_*) and skid register. State EMPTY(0), ONE(1), TWO(2); occupancy = state; out_valid = (state != EMPTY).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY:
  - push -> main<=in, go ONE.
  - otherwise stay EMPTY.
- ONE:
  - push & pop -> main<=in, stay ONE.
  - push & !pop -> skid<=in, go TWO.
  - !push & pop -> main_ctrl<=CTRL_RST, go EMPTY.
  - otherwise hold.
- TWO:
  - pop -> main<=skid, skid_ctrl<=CTRL_RST, go ONE.
  - no pop -> hold.
  - push is impossible because in_ready=0.
- in_ready is a flop: next value = (next_state != TWO) & !flush-suppression-free. in_ready depends only on registered state, never on same-cycle out_ready.
- Latency: one cycle from push into EMPTY to out_valid.
- Throughput: one entry per cycle when out_ready held high.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Data registers load only on push/skid-move; they hold otherwise, including on flush and pop-to-empty, to save power.
- Flush (priority over all transfers):
  - state<=EMPTY; main_ctrl and skid_ctrl <= CTRL_RST; data regs unchanged.
  - in_valid that cycle is dropped even if in_ready=1. Upstream must treat flush as also killing its own offer.
  - A pop coincident with flush still completes downstream, since out_* are register outputs sampled that edge.
  - in_ready next = 1.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, all ctrl regs=CTRL_RST, all data regs=0.
  - out_valid=0, occupancy=0, in_ready=0.
  - in_ready rises on the first clk edge after rst deasserts; no push can occur before that.
- Simultaneous flush and rst: rst dominates; results are identical anyway.
- out_data is don't-care when out_valid=0. out_ctrl is guaranteed CTRL_RST when out_valid=0.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams PIPE_EMPTY=2'd0, PIPE_ONE=2'd1, PIPE_TWO=2'd2.
  - per-stage CTRL_W/DATA_W constants and CTRL_RST bubble encodings for each stage boundary, sized from the existing SYSTEM_DEF widths.
- No sub-module: main and skid slots are two explicit register banks inside one module.

Test Plan:
- Reset: assert rst mid-cycle with state=TWO -> immediately out_valid=0, occupancy=0, out_ctrl=0, in_ready=0; after release, in_ready=1 at first edge.
- Streaming: in_valid=1 for 8 cycles with data 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on consecutive cycles starting one cycle after the first push; occupancy stays 1.
- Back-pressure: push 0xA1, 0xA2 with out_ready=0 -> occupancy=2, in_ready=0 next cycle, 0xA3 held upstream. Then out_ready=1 -> outputs 0xA1, 0xA2, 0xA3 in order, none lost.
- Flush at TWO: entries 0xB1/0xB2 held, flush=1 with in_valid=1 (0xB3) -> next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_RST, 0xB3 never appears; out_data still 0xB1.
- Pop to empty: single push ctrl=0x5A, out_ready=1 -> one cycle out_valid=1/out_ctrl=0x5A, then out_valid=0/out_ctrl=0x00, data unchanged.
- Random: random in_valid/out_ready/flush over 10k cycles against a 2-deep FIFO model. Check ordering, occupancy, and that in_ready=0 whenever occupancy=2.
